// File: rtl/page_nway_subdivide_router.sv
// page_nway_subdivide_router: steers BFT packets to N child leaves and merges leaf packets back round-robin
// Ports: clk/reset (async active-high); din_leaf_bft2interface/bft_ready = BFT input;
// dout_leaf_interface2bft/bft_accept = merged BFT output; leaf_dout/leaf_accept = per-leaf outputs;
// leaf_din/leaf_ready = per-leaf inputs; ap_start -> ap_start_leaf fan-out; drop_cnt = misaddressed drops.
module page_nway_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic empty, push, pop;
  assign empty = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign push = push_i & !full_o;
  assign pop = pop_i & !empty;
  // Empty reads as all-zero so a stale entry never shows a set valid bit
  assign dout_o = empty ? '0 : mem_q[rp_q];
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= push ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= din_i;
endmodule

module page_nway_subdivide_router #(
  parameter int N_LEAF = 4,
  parameter int PKT_W = 49,
  parameter int IDX_LSB = 44,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PKT_W-1:0]        din_leaf_bft2interface,
  output logic                    bft_ready,
  output logic [PKT_W-1:0]        dout_leaf_interface2bft,
  input  logic                    bft_accept,
  output logic [N_LEAF*PKT_W-1:0] leaf_dout,
  input  logic [N_LEAF-1:0]       leaf_accept,
  input  logic [N_LEAF*PKT_W-1:0] leaf_din,
  output logic [N_LEAF-1:0]       leaf_ready,
  input  logic                    ap_start,
  output logic [N_LEAF-1:0]       ap_start_leaf,
  output logic [15:0]             drop_cnt
);
  localparam int IDX_W = N_LEAF > 2 ? $clog2(N_LEAF) : 1;
  logic [IDX_W-1:0] idx, rr_q, rr_d, gnt, c;
  logic [IDX_W:0] s;
  logic [N_LEAF-1:0] of_full, if_full, if_empty;
  logic [PKT_W-1:0] if_head [N_LEAF];
  logic [PKT_W-1:0] obuf_q, obuf_d;
  logic [15:0] drop_q, drop_d;
  logic in_xfer, idx_bad, load, found;
  assign idx = din_leaf_bft2interface[IDX_LSB +: IDX_W];
  assign idx_bad = {1'b0, idx} >= (IDX_W+1)'(N_LEAF);
  // Ready ignores idx so there is no combinational din -> bft_ready path
  assign bft_ready = !reset & ~|of_full;
  assign in_xfer = din_leaf_bft2interface[PKT_W-1] & bft_ready;
  assign leaf_ready = ~if_full;
  assign load = !obuf_q[PKT_W-1] | bft_accept;
  assign dout_leaf_interface2bft = obuf_q;
  assign drop_cnt = drop_q;
  for (genvar i = 0; i < N_LEAF; i++) begin : g_leaf
    page_nway_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_ofifo (
      .clk(clk),
      .reset(reset),
      .push_i(in_xfer & !idx_bad & idx == IDX_W'(i)),
      .din_i(din_leaf_bft2interface),
      .pop_i(leaf_accept[i]),
      .dout_o(leaf_dout[i*PKT_W +: PKT_W]),
      .full_o(of_full[i])
    );
    page_nway_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_ififo (
      .clk(clk),
      .reset(reset),
      .push_i(leaf_din[i*PKT_W+PKT_W-1]),
      .din_i(leaf_din[i*PKT_W +: PKT_W]),
      .pop_i(load & found & gnt == IDX_W'(i)),
      .dout_o(if_head[i]),
      .full_o(if_full[i])
    );
    assign if_empty[i] = !if_head[i][PKT_W-1];
  end
  // Scan from the farthest candidate down so the one nearest rr_q wins
  always_comb begin
    gnt = rr_q;
    found = 1'b0;
    s = '0;
    c = '0;
    for (int k = N_LEAF-1; k >= 0; k--) begin
      s = {1'b0, rr_q} + (IDX_W+1)'(k);
      s = s >= (IDX_W+1)'(N_LEAF) ? s - (IDX_W+1)'(N_LEAF) : s;
      c = s[IDX_W-1:0];
      if (!if_empty[c]) begin
        gnt = c;
        found = 1'b1;
      end
    end
    obuf_d = load ? (found ? if_head[gnt] : '0) : obuf_q;
    rr_d = load & found ? (gnt == IDX_W'(N_LEAF-1) ? '0 : gnt + 1'b1) : rr_q;
    drop_d = in_xfer & idx_bad & drop_q != 16'hFFFF ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_q <= '0;
      obuf_q <= '0;
      drop_q <= '0;
      ap_start_leaf <= '0;
    end else begin
      rr_q <= rr_d;
      obuf_q <= obuf_d;
      drop_q <= drop_d;
      ap_start_leaf <= {N_LEAF{ap_start}};
    end
endmodule

// File: doc/page_nway_subdivide_router.md
# page_nway_subdivide_router

Parametrised N-leaf router for a subdivided page. Sits between one BFT leaf port and `N_LEAF` child leaf interfaces. It steers each incoming BFT packet to the child named in the packet's leaf-index field through per-leaf output FIFOs. It merges child-produced packets back onto the single BFT port through per-leaf input FIFOs and a round-robin arbiter. It also distributes `ap_start` to the children and counts misrouted packets.

## Interface
Parameters:
- `N_LEAF`, 4: number of child leaves; legal range 2..8.
- `PKT_W`, 49: packet width; bit `PKT_W-1` is the valid flag.
- `IDX_LSB`, 44: LSB of the leaf-index field; field width is `IDX_W = clog2(N_LEAF)`, minimum 1.
- `FIFO_DEPTH`, 4: entries per FIFO; must be a power of 2 and ≥2.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `din_leaf_bft2interface`, in, `PKT_W`: packet from BFT; valid when bit `PKT_W-1` = 1.
- `bft_ready`, out, 1: router can accept a BFT packet this cycle.
- `dout_leaf_interface2bft`, out, `PKT_W`: merged packet to BFT; bit `PKT_W-1` = valid.
- `bft_accept`, in, 1: BFT consumes `dout_leaf_interface2bft` this cycle.
- `leaf_dout`, out, `N_LEAF*PKT_W`: per-leaf packet; slice i = leaf i.
- `leaf_accept`, in, `N_LEAF`: leaf i consumes its slice.
- `leaf_din`, in, `N_LEAF*PKT_W`: per-leaf produced packet.
- `leaf_ready`, out, `N_LEAF`: router can accept from leaf i.
- `ap_start`, in, 1: page start.
- `ap_start_leaf`, out, `N_LEAF`: registered copy of `ap_start` to each leaf.
- `drop_cnt`, out, 16: saturating count of dropped misaddressed packets.

## Operation
- **Downstream path.** `idx = din[IDX_LSB +: IDX_W]`.
  - A transfer happens when `din[PKT_W-1] & bft_ready`.
  - `idx < N_LEAF`: push the full packet into `ofifo[idx]`.
  - `idx ≥ N_LEAF` (only possible when `N_LEAF` is not a power of 2): the packet is consumed but not stored. `drop_cnt` increments and saturates at 16'hFFFF.
- **bft_ready.** `bft_ready = !reset & (no ofifo full)`. This is conservative and independent of `idx`, so there is no combinational path from `din` to `bft_ready`.
- **Leaf output.** `leaf_dout[i]` is the head of `ofifo[i]` (show-ahead), with the valid bit forced to 0 when the FIFO is empty. A pop happens on `leaf_accept[i] & !empty`. `leaf_accept` while empty is ignored.
- **Upstream input.** `leaf_ready[i] = !ififo[i].full`. A push happens on `leaf_din[i][PKT_W-1] & leaf_ready[i]`.
- **Arbiter.**
  - Output register `obuf` (valid + data) drives `dout_leaf_interface2bft`.
  - `obuf` is loadable when it is empty or when `bft_accept` is high this cycle.
  - When loadable, grant the first non-empty `ififo` starting at `rr_ptr`, searching ascending with wrap.
  - Pop the granted FIFO, load `obuf`, and set `rr_ptr <= grant+1` (mod `N_LEAF`).
  - If loadable and all `ififo` are empty: `obuf` valid ← 0, `rr_ptr` unchanged.
  - `bft_accept` while `obuf` is empty is ignored.
- **Simultaneous push/pop** on a full FIFO is not allowed: a full FIFO deasserts ready. A simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- **Start fan-out.** `ap_start_leaf <= {N_LEAF{ap_start}}` every cycle.
- **Packet integrity.** Packets are never modified; the index bits are passed through.

## Timing
- **Reset values** (asynchronous assertion):
  - all FIFOs empty;
  - `rr_ptr` = 0;
  - `obuf` valid = 0 and data = 0, so `dout_leaf_interface2bft` = 0;
  - `leaf_dout` all 0;
  - `drop_cnt` = 0;
  - `ap_start_leaf` = 0;
  - `bft_ready` = 0 while `reset` is high, 1 on the first cycle after release;
  - `leaf_ready` = all 1 after release.
- **Reset mid-operation** discards all in-flight packets; nothing is emitted afterwards.
- **Downstream latency.** A packet accepted at edge k is visible on `leaf_dout[idx]` after edge k (the next cycle). Throughput is 1 packet/cycle while no FIFO is full.
- **Upstream latency.** Leaf push at edge k → the FIFO is non-empty after k → `obuf` loads at edge k+1 → the packet is on `dout_leaf_interface2bft` after k+1 (2-cycle latency). Sustained throughput is 1/cycle with `bft_accept` held high.
- **Fairness.** With all `ififo` non-empty and `bft_accept` held high, grants cycle 0,1,…,N_LEAF-1,0,…
- **Full boundary.** After `FIFO_DEPTH` pushes with no pops, `leaf_ready[i]`/`bft_ready` fall in the same cycle the count reaches `FIFO_DEPTH`. They rise the cycle after the first pop.
- **ap_start_leaf** lags `ap_start` by 1 cycle.

## Test plan
- **Reset and routing.** After reset, send packets with idx 0,1,2,3 (`N_LEAF`=4), payload = idx, no `leaf_accept` → each `leaf_dout[i]` shows valid with payload i one cycle after its send. `drop_cnt` = 0.
- **Downstream backpressure.** Send 5 packets to leaf 2 with `FIFO_DEPTH`=4, `leaf_accept`=0 → `bft_ready` drops after the 4th packet, the 5th is held by the source. Pulse `leaf_accept[2]` → `bft_ready` = 1 the next cycle and order is preserved 1..5.
- **Round-robin merge.** Preload all 4 `ififo` with 2 packets each, then hold `bft_accept`=1 → output leaf order 0,1,2,3,0,1,2,3, one per cycle, first packet 2 cycles after the first push.
- **Upstream stall.** Hold `bft_accept`=0 with leaf 1 sending continuously → `obuf` holds its first packet stable, `leaf_ready[1]` falls after `FIFO_DEPTH` pushes. Release → no loss, no duplication.
- **Misaddressed drop.** With `N_LEAF`=3, send idx=3 → no `leaf_dout` becomes valid and `drop_cnt`=1. Preset 65535 drops → `drop_cnt` stays 16'hFFFF.
- **Reset mid-traffic.** Assert `reset` for 1 cycle with all FIFOs partially full and `obuf` valid → all outputs are 0 immediately and `bft_ready`=1 after release. No stale packet appears on any output.
